// File: rtl/fx3_stream_writer_if.sv
// Signal bundle between the FX3 stream writer, the sample FIFO flags, the GPIF pins
// and the host register block. The writer uses the master side.
interface fx3_stream_writer_if #(
    parameter int THREADS = 2,
    parameter int TW      = 2,
    parameter int LEVEL_W = 10
);
    logic               enable;
    logic               fx3_nReady;
    logic [THREADS-1:0] fx3_thReady;
    logic [THREADS-1:0] fx3_thWatermark;
    logic [LEVEL_W-1:0] fifoLevel;
    logic               fx3_nWrite;
    logic               fifoRead;
    logic [TW-1:0]      fx3_threadAddr;
    logic               busy;
    logic [15:0]        underrunCount;
    logic [31:0]        bufferCount;

    modport master (
        input  enable, fx3_nReady, fx3_thReady, fx3_thWatermark, fifoLevel,
        output fx3_nWrite, fifoRead, fx3_threadAddr, busy, underrunCount, bufferCount
    );

    modport slave (
        output enable, fx3_nReady, fx3_thReady, fx3_thWatermark, fifoLevel,
        input  fx3_nWrite, fifoRead, fx3_threadAddr, busy, underrunCount, bufferCount
    );
endinterface

// File: rtl/fx3_stream_writer.sv
// FX3 GPIF-II write controller: streams FIFO words into 1..4 DMA threads round-robin,
// one full buffer per turn, pausing on FIFO underrun.
module fx3_stream_writer #(
    parameter int THREADS       = 2,
    parameter int TW            = 2,
    parameter int LEVEL_W       = 10,
    parameter int LOW_LEVEL     = 16,
    parameter int RESUME_LEVEL  = 512,
    parameter int POST_WM_WORDS = 3,
    parameter int TURN_DELAY    = 2
) (
    input  logic                fx3_clock,
    input  logic                fx3_reset,
    fx3_stream_writer_if.master bus
);
    localparam int PW = (POST_WM_WORDS > 0) ? $clog2(POST_WM_WORDS + 1) : 1;
    localparam int DW = $clog2(TURN_DELAY + 1);
    localparam logic [LEVEL_W-1:0] LOW_LVL    = LEVEL_W'(LOW_LEVEL);
    localparam logic [LEVEL_W-1:0] RESUME_LVL = LEVEL_W'(RESUME_LEVEL);
    localparam logic [TW-1:0]      LAST_ADDR  = TW'(THREADS - 1);

    typedef enum logic [2:0] {
        IDLE, WAIT_READY, WAIT_WM, SEND, POST, UNDERRUN, TURN
    } state_e;

    state_e             state_q, state_d;
    logic [PW-1:0]      post_cnt_q, post_cnt_d;
    logic [DW-1:0]      turn_cnt_q, turn_cnt_d;
    logic [TW-1:0]      addr_q, addr_d;
    logic [15:0]        underrun_q, underrun_d;
    logic [31:0]        buffer_q, buffer_d;
    logic               nwrite_q, nwrite_d;
    logic               busy_q, busy_d;
    logic               nready_q;
    logic [THREADS-1:0] thready_q;
    logic [THREADS-1:0] thwm_q;
    logic               ready_sel;
    logic               wm_sel;

    always_comb begin
        ready_sel = 1'b0;
        wm_sel    = 1'b0;
        for (int i = 0; i < THREADS; i++) begin
            if (addr_q == TW'(i)) begin
                ready_sel = thready_q[i];
                wm_sel    = thwm_q[i];
            end
        end
    end

    always_comb begin
        // NOTE: every next-state variable is given its hold value first, so no branch can leave it unassigned and infer a latch.
        state_d    = state_q;
        post_cnt_d = post_cnt_q;
        turn_cnt_d = turn_cnt_q;
        addr_d     = addr_q;
        underrun_d = underrun_q;
        buffer_d   = buffer_q;

        case (state_q)
            IDLE: begin
                if (bus.enable) state_d = WAIT_READY;
            end
            WAIT_READY: begin
                if (!bus.enable) begin
                    state_d = IDLE;
                end else if (ready_sel && !nready_q && (bus.fifoLevel > LOW_LVL)) begin
                    state_d = WAIT_WM;
                end
            end
            WAIT_WM: begin
                if (wm_sel) state_d = SEND;
            end
            SEND: begin
                // A falling watermark wins over a simultaneous underrun: the buffer is finishing anyway.
                if (!wm_sel) begin
                    if (POST_WM_WORDS == 0) begin
                        state_d    = TURN;
                        turn_cnt_d = DW'(TURN_DELAY);
                    end else begin
                        state_d    = POST;
                        post_cnt_d = PW'(POST_WM_WORDS);
                    end
                end else if (bus.fifoLevel <= LOW_LVL) begin
                    state_d = UNDERRUN;
                    if (underrun_q != 16'hFFFF) underrun_d = underrun_q + 16'd1;
                end
            end
            POST: begin
                post_cnt_d = post_cnt_q - PW'(1);
                if (post_cnt_q == PW'(1)) begin
                    state_d    = TURN;
                    turn_cnt_d = DW'(TURN_DELAY);
                end
            end
            UNDERRUN: begin
                if (bus.fifoLevel >= RESUME_LVL) state_d = SEND;
            end
            TURN: begin
                turn_cnt_d = turn_cnt_q - DW'(1);
                if (turn_cnt_q == DW'(1)) begin
                    state_d  = WAIT_READY;
                    buffer_d = buffer_q + 32'd1;
                    addr_d   = (addr_q == LAST_ADDR) ? '0 : addr_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobe and busy are decoded from the next state so they line up with the state register.
    assign nwrite_d = !((state_d == SEND) || (state_d == POST));
    assign busy_d   = (state_d != IDLE);

    always_ff @(posedge fx3_clock) begin
        // NOTE: sequential state uses non-blocking assignment so every register updates from pre-edge values.
        if (fx3_reset) begin
            state_q    <= IDLE;
            post_cnt_q <= '0;
            turn_cnt_q <= '0;
            addr_q     <= '0;
            underrun_q <= '0;
            buffer_q   <= '0;
            nwrite_q   <= 1'b1;
            busy_q     <= 1'b0;
            nready_q   <= 1'b0;
            thready_q  <= '0;
            thwm_q     <= '0;
        end else begin
            state_q    <= state_d;
            post_cnt_q <= post_cnt_d;
            turn_cnt_q <= turn_cnt_d;
            addr_q     <= addr_d;
            underrun_q <= underrun_d;
            buffer_q   <= buffer_d;
            nwrite_q   <= nwrite_d;
            busy_q     <= busy_d;
            nready_q   <= bus.fx3_nReady;
            thready_q  <= bus.fx3_thReady;
            thwm_q     <= bus.fx3_thWatermark;
        end
    end

    assign bus.fx3_nWrite     = nwrite_q;
    assign bus.fifoRead       = ~nwrite_q;
    assign bus.fx3_threadAddr = addr_q;
    assign bus.busy           = busy_q;
    assign bus.underrunCount  = underrun_q;
    assign bus.bufferCount    = buffer_q;
endmodule
